// File: rtl/prt_vtb_pkg.sv
// Shared types for the VTB timing generator: FSM states, timing set, widths.
package prt_vtb_pkg;

    localparam int P_CNT_W_DEF = 16;

    typedef logic [P_CNT_W_DEF-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RUN
    } state_t;

    typedef struct packed {
        cnt_t htotal;
        cnt_t hstart;
        cnt_t hwidth;
        cnt_t hsw;
        cnt_t vtotal;
        cnt_t vstart;
        cnt_t vheight;
        cnt_t vsw;
    } tcfg_t;

endpackage

// File: rtl/prt_vtb_tg_if.sv
// Config / video / status bundle of the timing generator.
interface prt_vtb_tg_if
    import prt_vtb_pkg::*;
#(
    parameter int P_CNT_W = P_CNT_W_DEF
);
    logic               CFG_RUN_IN;
    logic [P_CNT_W-1:0] CFG_HTOTAL_IN;
    logic [P_CNT_W-1:0] CFG_HSTART_IN;
    logic [P_CNT_W-1:0] CFG_HWIDTH_IN;
    logic [P_CNT_W-1:0] CFG_HSW_IN;
    logic [P_CNT_W-1:0] CFG_VTOTAL_IN;
    logic [P_CNT_W-1:0] CFG_VSTART_IN;
    logic [P_CNT_W-1:0] CFG_VHEIGHT_IN;
    logic [P_CNT_W-1:0] CFG_VSW_IN;
    logic               VID_SOF_OUT;
    logic               VID_EOL_OUT;
    logic               VID_VLD_OUT;
    logic               VID_HS_OUT;
    logic               VID_VS_OUT;
    logic               STA_RUN_OUT;
    logic               STA_ERR_OUT;
    logic [P_CNT_W-1:0] STA_FRM_OUT;

    modport master (
        output CFG_RUN_IN, CFG_HTOTAL_IN, CFG_HSTART_IN, CFG_HWIDTH_IN, CFG_HSW_IN,
               CFG_VTOTAL_IN, CFG_VSTART_IN, CFG_VHEIGHT_IN, CFG_VSW_IN,
        input  VID_SOF_OUT, VID_EOL_OUT, VID_VLD_OUT, VID_HS_OUT, VID_VS_OUT,
               STA_RUN_OUT, STA_ERR_OUT, STA_FRM_OUT
    );

    modport slave (
        input  CFG_RUN_IN, CFG_HTOTAL_IN, CFG_HSTART_IN, CFG_HWIDTH_IN, CFG_HSW_IN,
               CFG_VTOTAL_IN, CFG_VSTART_IN, CFG_VHEIGHT_IN, CFG_VSW_IN,
        output VID_SOF_OUT, VID_EOL_OUT, VID_VLD_OUT, VID_HS_OUT, VID_VS_OUT,
               STA_RUN_OUT, STA_ERR_OUT, STA_FRM_OUT
    );

endinterface

// File: rtl/prt_vtb_tg_cfg.sv
// Shadow copy of the timing set, frozen for a whole frame, plus legality check.
module prt_vtb_tg_cfg
    import prt_vtb_pkg::*;
#(
    parameter int P_PPC = 2
) (
    input  logic  clk_i,
    input  logic  rst_n_i,
    input  logic  latch_i,
    input  tcfg_t cfg_i,
    output tcfg_t cfg_o,
    output logic  ok_o
);
    localparam cnt_t PPC = cnt_t'(P_PPC);

    tcfg_t                shd_q;
    logic [P_CNT_W_DEF:0] hend;
    logic [P_CNT_W_DEF:0] vend;

    // Capture the live config only when the FSM asks for it.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            shd_q <= '0;
        end else if (latch_i) begin
            shd_q <= cfg_i;
        end
    end

    // Legality of the shadow set; sums carry one extra bit so they cannot wrap.
    always_comb begin
        hend = {1'b0, shd_q.hstart} + {1'b0, shd_q.hwidth};
        vend = {1'b0, shd_q.vstart} + {1'b0, shd_q.vheight};
        ok_o = (shd_q.hwidth != '0) && (shd_q.vheight != '0)
            && (hend <= {1'b0, shd_q.htotal}) && (vend <= {1'b0, shd_q.vtotal})
            && (shd_q.hsw <= shd_q.htotal) && (shd_q.vsw <= shd_q.vtotal)
            && ((shd_q.htotal % PPC) == '0) && ((shd_q.hstart % PPC) == '0)
            && ((shd_q.hwidth % PPC) == '0) && ((shd_q.hsw % PPC) == '0);
    end

    assign cfg_o = shd_q;

endmodule

// File: rtl/prt_vtb_tg.sv
// VTB timing generator: frame FSM, h/v counters and registered sync/active decode.
module prt_vtb_tg
    import prt_vtb_pkg::*;
#(
    parameter int P_PPC   = 2,
    parameter int P_CNT_W = P_CNT_W_DEF
) (
    input  logic        CLK_IN,
    input  logic        RST_IN,
    prt_vtb_tg_if.slave bus
);
    localparam logic [P_CNT_W-1:0] PPC = P_CNT_W'(P_PPC);

    state_t             st_q;
    logic [P_CNT_W-1:0] h_q, v_q, frm_q;
    logic               sof_q, eol_q, vld_q, hs_q, vs_q, err_q;

    tcfg_t              cfg_in, cfg;
    logic               cfg_ok, latch;
    logic               run, hact, vact, h_last, v_last;
    logic               sof_d, eol_d, vld_d, hs_d, vs_d;
    logic [P_CNT_W:0]   hend, vend;

    assign cfg_in = '{htotal:  bus.CFG_HTOTAL_IN,  hstart: bus.CFG_HSTART_IN,
                      hwidth:  bus.CFG_HWIDTH_IN,  hsw:    bus.CFG_HSW_IN,
                      vtotal:  bus.CFG_VTOTAL_IN,  vstart: bus.CFG_VSTART_IN,
                      vheight: bus.CFG_VHEIGHT_IN, vsw:    bus.CFG_VSW_IN};

    assign latch = (st_q == ST_IDLE) && bus.CFG_RUN_IN;

    prt_vtb_tg_cfg #(.P_PPC(P_PPC)) u_cfg (
        .clk_i   (CLK_IN),
        .rst_n_i (RST_IN),
        .latch_i (latch),
        .cfg_i   (cfg_in),
        .cfg_o   (cfg),
        .ok_o    (cfg_ok)
    );

    // Decode of the current beat; forced low outside RUN so boundary cycles stay quiet.
    always_comb begin
        run    = (st_q == ST_RUN);
        hend   = {1'b0, cfg.hstart} + {1'b0, cfg.hwidth};
        vend   = {1'b0, cfg.vstart} + {1'b0, cfg.vheight};
        hact   = (h_q >= cfg.hstart) && ({1'b0, h_q} < hend);
        vact   = (v_q >= cfg.vstart) && ({1'b0, v_q} < vend);
        vld_d  = run && hact && vact;
        eol_d  = run && vact && ({1'b0, h_q} == hend - (P_CNT_W+1)'(P_PPC));
        sof_d  = run && (v_q == cfg.vstart) && (h_q == cfg.hstart);
        hs_d   = run && (h_q < cfg.hsw);
        vs_d   = run && (v_q < cfg.vsw);
        h_last = (h_q == cfg.htotal - PPC);
        v_last = (v_q == cfg.vtotal - P_CNT_W'(1));
    end

    // Frame FSM, counters and registered outputs.
    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) begin
            st_q  <= ST_IDLE;
            h_q   <= '0;
            v_q   <= '0;
            frm_q <= '0;
            err_q <= 1'b0;
            sof_q <= 1'b0;
            eol_q <= 1'b0;
            vld_q <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
        end else begin
            sof_q <= sof_d;
            eol_q <= eol_d;
            vld_q <= vld_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            case (st_q)
                ST_IDLE: begin
                    if (bus.CFG_RUN_IN) begin
                        st_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    h_q <= '0;
                    v_q <= '0;
                    if (cfg_ok) begin
                        err_q <= 1'b0;
                        st_q  <= ST_RUN;
                    end else begin
                        err_q <= 1'b1;
                        st_q  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (h_last) begin
                        h_q <= '0;
                        if (v_last) begin
                            // End of frame: the IDLE pass doubles as the re-latch cycle.
                            v_q   <= '0;
                            frm_q <= frm_q + P_CNT_W'(1);
                            st_q  <= ST_IDLE;
                        end else begin
                            v_q <= v_q + P_CNT_W'(1);
                        end
                    end else begin
                        h_q <= h_q + PPC;
                    end
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.VID_SOF_OUT = sof_q;
    assign bus.VID_EOL_OUT = eol_q;
    assign bus.VID_VLD_OUT = vld_q;
    assign bus.VID_HS_OUT  = hs_q;
    assign bus.VID_VS_OUT  = vs_q;
    assign bus.STA_RUN_OUT = (st_q == ST_RUN);
    assign bus.STA_ERR_OUT = err_q;
    assign bus.STA_FRM_OUT = frm_q;

endmodule
